// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame
// geometry and the baud-counter width helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Width of a down-counter that must hold values up to ticks-1.
    function automatic int unsigned baud_cnt_w(input int unsigned ticks);
        return $clog2(ticks);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery channel between the UART receiver and its consumer.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value both flops take in reset (use the line's idle level).
module uart_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Resample the async input twice to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 serial line to bytes on a valid/ready channel, with
// single-cycle frame_err and overrun pulses. Bits are sampled mid-period.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit (8E1 frames).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BAUD = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    uart_rx_if.master   bus,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned       CNT_W    = baud_cnt_w(TICKS_PER_BAUD);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(TICKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(TICKS_PER_BAUD / 2 - 1);

    logic                 w_rx_s;
    logic                 r_rx_prev;
    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_cnt_zero;
    logic w_load_half;
    logic w_load_full;
    logic w_shift_en;
    logic w_clr_idx;
    logic w_complete;
    logic w_bad_frame;
    logic w_par_sample;
    logic w_par_bad;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    // Latch the parity verdict so it can be applied at the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par_err <= 1'b0;
        else if (w_par_sample)
            r_par_err <= ^{r_shift, w_rx_s};
    end

    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rx_prev <= 1'b1;
        else
            r_rx_prev <= w_rx_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_load_half  = 1'b0;
        w_load_full  = 1'b0;
        w_shift_en   = 1'b0;
        w_clr_idx    = 1'b0;
        w_complete   = 1'b0;
        w_bad_frame  = 1'b0;
        w_par_sample = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s && r_rx_prev) begin
                    w_state_next = START;
                    w_load_half  = 1'b1;
                end
            end
            START: begin
                if (w_cnt_zero) begin
                    if (w_rx_s) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                        w_load_full  = 1'b1;
                        w_clr_idx    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_cnt_zero) begin
                    w_shift_en  = 1'b1;
                    w_load_full = 1'b1;
                    if (r_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_cnt_zero) begin
                    w_par_sample = 1'b1;
                    w_load_full  = 1'b1;
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_cnt_zero) begin
                    w_state_next = IDLE;
                    if (w_rx_s && !w_par_bad)
                        w_complete = 1'b1;
                    else
                        w_bad_frame = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Baud down-counter: reload on demand, otherwise count to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_load_half)
            r_cnt <= CNT_HALF;
        else if (w_load_full)
            r_cnt <= CNT_FULL;
        else if (!w_cnt_zero)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    // LSB-first shift register and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            if (w_clr_idx)
                r_idx <= '0;
            else if (w_shift_en)
                r_idx <= r_idx + 3'd1;
            if (w_shift_en)
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    // Output holding register, handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_frame;
            r_overrun   <= w_complete && r_valid && !bus.ready;
            if (w_complete && (!r_valid || bus.ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data  = r_data;
    assign bus.valid = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned TICKS = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic frame_err;
    logic overrun;

    uart_rx_if u_if ();

    uart_rx #(.TICKS_PER_BAUD(TICKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .bus       (u_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Running event counts, sampled just after each rising edge.
    int         n_valid_cyc = 0;
    int         n_ferr      = 0;
    int         n_ovr       = 0;
    logic [7:0] last_data   = '0;

    always begin
        @(posedge clk);
        #1;
        if (u_if.valid === 1'b1) begin
            n_valid_cyc++;
            last_data = u_if.data;
        end
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (TICKS) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop. Line left at stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic good_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ !good_par);
`else
        if (!good_par) idle(0);
`endif
        send_bit(stop_lvl);
    endtask

    int v0, f0, o0;

    initial begin
        rx         = 1'b1;
        u_if.ready = 1'b0;
        rst_n      = 1'b0;
        idle(3);
        check("rst_valid", 32'(u_if.valid), 32'd0);
        check("rst_data", 32'(u_if.data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // 0xA5 with ready high: exactly one valid cycle.
        u_if.ready = 1'b1;
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(20);
        check("a5_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
        check("a5_data", 32'(last_data), 32'hA5);
        check("a5_frame_err", 32'(n_ferr - f0), 32'd0);
        check("a5_overrun", 32'(n_ovr - o0), 32'd0);
        check("a5_valid_after", 32'(u_if.valid), 32'd0);

        // 0x3C held while ready is low, released one cycle after ready.
        u_if.ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(40);
        check("3c_held_valid", 32'(u_if.valid), 32'd1);
        check("3c_held_data", 32'(u_if.data), 32'h3C);
        u_if.ready = 1'b1;
        idle(1);
        check("3c_valid_dropped", 32'(u_if.valid), 32'd0);
        check("3c_data_kept", 32'(u_if.data), 32'h3C);
        u_if.ready = 1'b0;
        idle(5);

        // 0x11 then 0x22 back-to-back unaccepted: overrun, old byte retained.
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(20);
        check("ovr_valid", 32'(u_if.valid), 32'd1);
        check("ovr_data", 32'(u_if.data), 32'h11);
        check("ovr_pulses", 32'(n_ovr - o0), 32'd1);
        check("ovr_frame_err", 32'(n_ferr - f0), 32'd0);
        u_if.ready = 1'b1;
        idle(1);
        u_if.ready = 1'b0;
        check("ovr_accepted", 32'(u_if.valid), 32'd0);
        idle(5);

        // Short low glitch: back to idle silently.
        v0 = n_valid_cyc; f0 = n_ferr;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        check("glitch_valid_cycles", 32'(n_valid_cyc - v0), 32'd0);
        check("glitch_frame_err", 32'(n_ferr - f0), 32'd0);

        // 0x55 with low stop bit, line stuck low, then a good 0x0F.
        u_if.ready = 1'b1;
        v0 = n_valid_cyc; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(100);
        check("ferr_pulses", 32'(n_ferr - f0), 32'd1);
        check("ferr_no_valid", 32'(n_valid_cyc - v0), 32'd0);
        rx = 1'b1;
        idle(20);
        v0 = n_valid_cyc;
        send_frame(8'h0F, 1'b1, 1'b1);
        idle(20);
        check("after_ferr_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
        check("after_ferr_data", 32'(last_data), 32'h0F);

        // Reset asserted in the middle of bit 4 of 0xFF.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        idle(8);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(u_if.valid), 32'd0);
        check("midrst_data", 32'(u_if.data), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        idle(5);
        rst_n = 1'b1;
        v0 = n_valid_cyc; f0 = n_ferr;
        idle(80);
        check("postrst_quiet_valid", 32'(n_valid_cyc - v0), 32'd0);
        check("postrst_quiet_ferr", 32'(n_ferr - f0), 32'd0);
        v0 = n_valid_cyc;
        send_frame(8'h81, 1'b1, 1'b1);
        idle(20);
        check("postrst_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
        check("postrst_data", 32'(last_data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x81 with the parity bit inverted.
        v0 = n_valid_cyc; f0 = n_ferr;
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("par_frame_err", 32'(n_ferr - f0), 32'd1);
        check("par_no_valid", 32'(n_valid_cyc - v0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
